multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Multi-cycle sequencer for the MIPS-subset datapath (add/sub/and/or/slt, lw, sw, beq, j).
//  Replaces single-cycle decode with an FSM that shares one ALU and one memory port across steps.
//  Drives PC, IR, register-file, memory and ALU-mux enables each cycle.
//  Stalls on a memory-ready handshake.
// PARAMETERS
//  CNT_W   32   width of performance counters (used only with MC_CTRL_PERF_EN)
// PORTS
//  clk        in   1   clock, rising edge
//  rst        in   1   reset, asynchronous, active-high
//  op         in   6   IR[31:26], valid from DECODE onward
//  func       in   6   IR[5:0]
//  mem_ready  in   1   memory access completes this cycle
//  PCWr       out  1   unconditional PC write
//  PCWrCond   out  1   PC write if ALU zero (datapath gates)
//  PCSrc      out  2   00 ALU result, 01 ALUOut reg, 10 jump target
//  IorD       out  1   memory address: 0 PC, 1 ALUOut
//  MemRd      out  1   memory read request
//  MemWr      out  1   memory write request
//  IRWr       out  1   instruction register load
//  RegDst     out  1   write register: 0 rt, 1 rd
//  MemtoReg   out  1   write data: 0 ALUOut, 1 MDR
//  RegWr      out  1   register-file write
//  ALUSrcA    out  1   0 PC, 1 reg A
//  ALUSrcB    out  2   00 reg B, 01 const 4, 10 ext imm, 11 ext imm<<2
//  ALUop      out  3   000 add, 001 sub, 010 and, 011 or, 111 slt, 110 other R-type
//  ExtOp      out  1   1 sign-extend immediate
//  illegal    out  1   1-cycle pulse in DECODE on unsupported op
//  instr_done out  1   1-cycle pulse in final state of each instruction
// BEHAVIOUR
//  - States: IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, REX, RWB, BEQ, JMP.
//  - Reset: state=IDLE, all outputs 0. IDLE->FETCH unconditionally next cycle.
//  - Assertion of rst in any state forces IDLE asynchronously; MemRd/MemWr/RegWr drop immediately.
//  - Outputs are decoded from state (Moore); exceptions are PCWr/IRWr in FETCH, which are gated by mem_ready.
//  - FETCH: IorD=0, MemRd=1, ALUSrcA=0, ALUSrcB=01, ALUop=000, PCSrc=00; PCWr=IRWr=mem_ready.
//    Holds until mem_ready=1, then -> DECODE.
//  - DECODE: ALUSrcA=0, ALUSrcB=11, ALUop=000, ExtOp=1 (branch target to ALUOut).
//    Next state by op: 100011/101011->MEMADR, 000000->REX, 000100->BEQ, 000010->JMP.
//    Any other op: illegal=1, -> FETCH (instruction treated as NOP).
//  - MEMADR: ALUSrcA=1, ALUSrcB=10, ExtOp=1, ALUop=000; lw->MEMRD, sw->MEMWR.
//  - MEMRD: IorD=1, MemRd=1; hold until mem_ready, then -> MEMWB.
//  - MEMWB: RegDst=0, MemtoReg=1, RegWr=1, instr_done=1 -> FETCH.
//  - MEMWR: IorD=1, MemWr=1; hold until mem_ready; instr_done=1 in the completing cycle -> FETCH.
//  - REX: ALUSrcA=1, ALUSrcB=00, ALUop decoded from func (unknown func -> 110) -> RWB.
//  - RWB: RegDst=1, MemtoReg=0, RegWr=1, instr_done=1 -> FETCH.
//  - BEQ: ALUSrcA=1, ALUSrcB=00, ALUop=001, PCWrCond=1, PCSrc=01, instr_done=1 -> FETCH.
//  - JMP: PCWr=1, PCSrc=10, instr_done=1 -> FETCH.
//  - Cycle counts with mem_ready=1: lw 5, sw 4, R 4, beq 3, j 3, illegal 2. Each stall cycle adds 1.
//  - Unlisted outputs are 0 in every state. op/func are sampled only in DECODE/REX/MEMADR.
// CONFIGURATION
//  - MC_CTRL_PERF_EN defined: adds ports cyc_cnt[CNT_W-1:0] and instr_cnt[CNT_W-1:0], both 0 on reset.
//    cyc_cnt increments every cycle outside IDLE.
//    instr_cnt increments on instr_done. Both wrap modulo 2^CNT_W.
//  - MC_CTRL_PERF_EN undefined: these ports and their logic are absent; all other behaviour is identical.
// STRUCTURE
//  - Package mc_ctrl_pkg holds: state encoding; opcode constants (RTYPE, LW, SW, BEQ, J);
//    funct constants; ALUop codes; ALUSrcB/PCSrc encodings.
//  - Sub-module alu_op_decode: combinational func->ALUop mapping, used in REX.
// TESTING
//  - lw (op 100011), mem_ready=1: states FETCH,DECODE,MEMADR,MEMRD,MEMWB.
//    RegWr=1 and MemtoReg=1 only in cycle 5; instr_done in cycle 5.
//  - lw with mem_ready=0 for 3 cycles in MEMRD: MemRd=1,IorD=1 held for 4 cycles; total 8 cycles; no RegWr before MEMWB.
//  - R-type func 101010: ALUop=111 in REX, RegDst=1/RegWr=1 in RWB.
//    func 100111: ALUop=110.
//  - beq: cycle 3 shows PCWrCond=1, PCSrc=01, ALUop=001, PCWr=0.
//    j: cycle 3 shows PCWr=1, PCSrc=10.
//  - op 111111: illegal=1 in DECODE, next state FETCH, no RegWr/MemWr asserted.
//  - rst during MEMWR with mem_ready=0: MemWr=0 before the next edge, state IDLE, FETCH one cycle after release.
//    With MC_CTRL_PERF_EN: after three j instructions, instr_cnt=3.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset controller: states, opcodes,
// funct codes, ALU operations, mux selects and the registered control word.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_REX,
        S_RWB,
        S_BEQ,
        S_JMP
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b011;
    localparam logic [2:0] ALU_OTHER = 3'b110;
    localparam logic [2:0] ALU_SLT   = 3'b111;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Pure Moore part of the outputs; mem_ready/op dependent terms are added in the top.
    typedef struct packed {
        logic       pc_wr;
        logic       pc_wr_cond;
        logic [1:0] pc_src;
        logic       i_or_d;
        logic       mem_rd;
        logic       mem_wr;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_wr;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       ext_op;
        logic       instr_done;
    } ctrl_t;

    function automatic ctrl_t ctrl_for_state(input state_t s, input logic [2:0] rex_op);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_rd    = 1'b1;
                c.alu_src_b = SRCB_FOUR;
                c.alu_op    = ALU_ADD;
                c.pc_src    = PCSRC_ALU;
            end
            S_DECODE: begin
                c.alu_src_b = SRCB_IMM_SH2;
                c.alu_op    = ALU_ADD;
                c.ext_op    = 1'b1;
            end
            S_MEMADR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALU_ADD;
                c.ext_op    = 1'b1;
            end
            S_MEMRD: begin
                c.i_or_d = 1'b1;
                c.mem_rd = 1'b1;
            end
            S_MEMWB: begin
                c.mem_to_reg = 1'b1;
                c.reg_wr     = 1'b1;
                c.instr_done = 1'b1;
            end
            S_MEMWR: begin
                c.i_or_d = 1'b1;
                c.mem_wr = 1'b1;
            end
            S_REX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_REG;
                c.alu_op    = rex_op;
            end
            S_RWB: begin
                c.reg_dst    = 1'b1;
                c.reg_wr     = 1'b1;
                c.instr_done = 1'b1;
            end
            S_BEQ: begin
                c.alu_src_a  = 1'b1;
                c.alu_src_b  = SRCB_REG;
                c.alu_op     = ALU_SUB;
                c.pc_wr_cond = 1'b1;
                c.pc_src     = PCSRC_ALUOUT;
                c.instr_done = 1'b1;
            end
            S_JMP: begin
                c.pc_wr      = 1'b1;
                c.pc_src     = PCSRC_JUMP;
                c.instr_done = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_op_decode.sv
// Combinational R-type funct to ALU operation mapping; unknown funct codes map
// to the generic "other R-type" operation.
module alu_op_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] func,
    output logic [2:0] alu_op
);

    always_comb begin
        alu_op = ALU_OTHER;
        case (func)
            FN_ADD:  alu_op = ALU_ADD;
            FN_SUB:  alu_op = ALU_SUB;
            FN_AND:  alu_op = ALU_AND;
            FN_OR:   alu_op = ALU_OR;
            FN_SLT:  alu_op = ALU_SLT;
            default: alu_op = ALU_OTHER;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer for the MIPS-subset datapath (lw, sw, R-type, beq, j).
// Optional performance counters are built when MC_CTRL_PERF_EN is defined.
module multicycle_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic [5:0] func,
    input  logic       mem_ready,
    output logic       PCWr,
    output logic       PCWrCond,
    output logic [1:0] PCSrc,
    output logic       IorD,
    output logic       MemRd,
    output logic       MemWr,
    output logic       IRWr,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWr,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUop,
    output logic       ExtOp,
    output logic       illegal,
    output logic       instr_done
`ifdef MC_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] instr_cnt
`endif
);

    state_t     state_reg;
    state_t     state_next;
    ctrl_t      ctrl_reg;
    logic [2:0] rex_op;
    logic       op_legal;
    logic       in_fetch;
    logic       in_decode;
    logic       in_memwr;

    alu_op_decode u_alu_op_decode (
        .func   (func),
        .alu_op (rex_op)
    );

    assign op_legal = (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
                      (op == OP_BEQ) || (op == OP_J);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:   state_next = S_FETCH;
            S_FETCH:  if (mem_ready) state_next = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_RTYPE:     state_next = S_REX;
                    OP_BEQ:       state_next = S_BEQ;
                    OP_J:         state_next = S_JMP;
                    default:      state_next = S_FETCH;
                endcase
            end
            S_MEMADR: state_next = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_ready) state_next = S_MEMWB;
            S_MEMWR:  if (mem_ready) state_next = S_FETCH;
            S_REX:    state_next = S_RWB;
            S_MEMWB, S_RWB, S_BEQ, S_JMP: state_next = S_FETCH;
            default:  state_next = S_IDLE;
        endcase
    end

    // Control word is computed from the upcoming state so outputs come straight from flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
            ctrl_reg  <= '0;
        end else begin
            state_reg <= state_next;
            ctrl_reg  <= ctrl_for_state(state_next, rex_op);
        end
    end

    assign in_fetch  = (state_reg == S_FETCH);
    assign in_decode = (state_reg == S_DECODE);
    assign in_memwr  = (state_reg == S_MEMWR);

    assign PCWr       = ctrl_reg.pc_wr | (in_fetch & mem_ready);
    assign IRWr       = in_fetch & mem_ready;
    assign illegal    = in_decode & ~op_legal;
    assign instr_done = ctrl_reg.instr_done | (in_memwr & mem_ready);
    assign PCWrCond   = ctrl_reg.pc_wr_cond;
    assign PCSrc      = ctrl_reg.pc_src;
    assign IorD       = ctrl_reg.i_or_d;
    assign MemRd      = ctrl_reg.mem_rd;
    assign MemWr      = ctrl_reg.mem_wr;
    assign RegDst     = ctrl_reg.reg_dst;
    assign MemtoReg   = ctrl_reg.mem_to_reg;
    assign RegWr      = ctrl_reg.reg_wr;
    assign ALUSrcA    = ctrl_reg.alu_src_a;
    assign ALUSrcB    = ctrl_reg.alu_src_b;
    assign ALUop      = ctrl_reg.alu_op;
    assign ExtOp      = ctrl_reg.ext_op;

`ifdef MC_CTRL_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_cnt   <= '0;
            instr_cnt <= '0;
        end else begin
            if (state_reg != S_IDLE) cyc_cnt <= cyc_cnt + CNT_W'(1);
            if (instr_done) instr_cnt <= instr_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: stimulus queues the expected control word
// per cycle, a negedge monitor pops and compares against the DUT outputs.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] op = 6'd0;
    logic [5:0] func = 6'd0;
    logic       mem_ready = 1'b0;
    logic       PCWr, PCWrCond, IorD, MemRd, MemWr, IRWr, RegDst, MemtoReg, RegWr;
    logic       ALUSrcA, ExtOp, illegal, instr_done;
    logic [1:0] PCSrc, ALUSrcB;
    logic [2:0] ALUop;
`ifdef MC_CTRL_PERF_EN
    logic [31:0] cyc_cnt, instr_cnt;
`endif

    multicycle_ctrl #(.CNT_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .op         (op),
        .func       (func),
        .mem_ready  (mem_ready),
        .PCWr       (PCWr),
        .PCWrCond   (PCWrCond),
        .PCSrc      (PCSrc),
        .IorD       (IorD),
        .MemRd      (MemRd),
        .MemWr      (MemWr),
        .IRWr       (IRWr),
        .RegDst     (RegDst),
        .MemtoReg   (MemtoReg),
        .RegWr      (RegWr),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUop      (ALUop),
        .ExtOp      (ExtOp),
        .illegal    (illegal),
        .instr_done (instr_done)
`ifdef MC_CTRL_PERF_EN
        ,
        .cyc_cnt    (cyc_cnt),
        .instr_cnt  (instr_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pc_wr;
        logic       pc_wr_cond;
        logic [1:0] pc_src;
        logic       iord;
        logic       mem_rd;
        logic       mem_wr;
        logic       ir_wr;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_wr;
        logic       src_a;
        logic [1:0] src_b;
        logic [2:0] alu_op;
        logic       ext_op;
        logic       illegal;
        logic       done;
    } vec_t;

    typedef enum {
        T_IDLE, T_FETCH, T_DECODE, T_ILLEGAL, T_MEMADR, T_MEMRD, T_MEMWB,
        T_MEMWR, T_REX, T_RWB, T_BEQ, T_JMP
    } tst_t;

    vec_t act;
    assign act = {PCWr, PCWrCond, PCSrc, IorD, MemRd, MemWr, IRWr, RegDst,
                  MemtoReg, RegWr, ALUSrcA, ALUSrcB, ALUop, ExtOp, illegal, instr_done};

    vec_t exp_q[$];
    tst_t name_q[$];
    vec_t mon_exp;
    tst_t mon_name;
    int   total = 0;
    int   bad = 0;

    // Hand-written expected control word per state.
    function automatic vec_t expect_vec(input tst_t st, input logic mr, input logic [2:0] aop);
        vec_t v;
        v = '0;
        case (st)
            T_FETCH:   begin v.mem_rd = 1; v.src_b = 2'b01; v.pc_wr = mr; v.ir_wr = mr; end
            T_DECODE:  begin v.src_b = 2'b11; v.ext_op = 1; end
            T_ILLEGAL: begin v.src_b = 2'b11; v.ext_op = 1; v.illegal = 1; end
            T_MEMADR:  begin v.src_a = 1; v.src_b = 2'b10; v.ext_op = 1; end
            T_MEMRD:   begin v.iord = 1; v.mem_rd = 1; end
            T_MEMWB:   begin v.mem_to_reg = 1; v.reg_wr = 1; v.done = 1; end
            T_MEMWR:   begin v.iord = 1; v.mem_wr = 1; v.done = mr; end
            T_REX:     begin v.src_a = 1; v.alu_op = aop; end
            T_RWB:     begin v.reg_dst = 1; v.reg_wr = 1; v.done = 1; end
            T_BEQ:     begin v.src_a = 1; v.alu_op = 3'b001; v.pc_wr_cond = 1; v.pc_src = 2'b01; v.done = 1; end
            T_JMP:     begin v.pc_wr = 1; v.pc_src = 2'b10; v.done = 1; end
            default:   v = '0;
        endcase
        return v;
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_exp  = exp_q.pop_front();
            mon_name = name_q.pop_front();
            total++;
            if (act !== mon_exp) begin
                bad++;
                $display("FAIL %s @%0t: got %05h want %05h", mon_name.name(), $time, act, mon_exp);
            end else if (mon_exp.done || mon_exp.illegal) begin
                $display("txn end %s @%0t: outputs %05h", mon_name.name(), $time, act);
            end
        end
    end

    task automatic check(input string n, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", n, got, want);
        end
    endtask

    // Called at posedge+1: drive mem_ready, queue the expectation, advance one cycle.
    task automatic cyc(input logic mr, input tst_t st, input logic [2:0] aop);
        mem_ready = mr;
        exp_q.push_back(expect_vec(st, mr, aop));
        name_q.push_back(st);
        @(posedge clk);
        #1;
    endtask

    task automatic do_j();
        op = 6'b000010;
        cyc(1, T_FETCH, 0); cyc(1, T_DECODE, 0); cyc(1, T_JMP, 0);
    endtask

    task automatic do_rtype(input logic [5:0] fn, input logic [2:0] aop);
        op = 6'b000000; func = fn;
        cyc(1, T_FETCH, 0); cyc(1, T_DECODE, 0); cyc(1, T_REX, aop); cyc(1, T_RWB, 0);
    endtask

    initial begin
        @(posedge clk); #1;
        cyc(1, T_IDLE, 0);
        rst = 0;
        cyc(1, T_IDLE, 0);

        op = 6'b100011;
        cyc(1, T_FETCH, 0); cyc(1, T_DECODE, 0); cyc(1, T_MEMADR, 0);
        cyc(1, T_MEMRD, 0); cyc(1, T_MEMWB, 0);

        cyc(1, T_FETCH, 0); cyc(1, T_DECODE, 0); cyc(1, T_MEMADR, 0);
        repeat (3) cyc(0, T_MEMRD, 0);
        cyc(1, T_MEMRD, 0); cyc(1, T_MEMWB, 0);

        op = 6'b101011;
        cyc(1, T_FETCH, 0); cyc(1, T_DECODE, 0); cyc(1, T_MEMADR, 0);
        cyc(0, T_MEMWR, 0); cyc(1, T_MEMWR, 0);

        do_rtype(6'b101010, 3'b111);
        do_rtype(6'b100111, 3'b110);
        do_rtype(6'b100010, 3'b001);
        do_rtype(6'b100101, 3'b011);

        op = 6'b000100;
        cyc(0, T_FETCH, 0); cyc(1, T_FETCH, 0); cyc(1, T_DECODE, 0); cyc(1, T_BEQ, 0);

        do_j();

        op = 6'b111111;
        cyc(1, T_FETCH, 0); cyc(1, T_ILLEGAL, 0);
        do_j();

        // Asynchronous reset while a store is stalled.
        op = 6'b101011;
        cyc(1, T_FETCH, 0); cyc(1, T_DECODE, 0); cyc(1, T_MEMADR, 0);
        cyc(0, T_MEMWR, 0);
        check("memwr_before_rst", {31'd0, MemWr}, 32'd1);
        #2 rst = 1;
        #1;
        check("memwr_async_rst", {31'd0, MemWr}, 32'd0);
        check("outputs_async_rst", {12'd0, act}, 32'd0);
        @(posedge clk); #1;
        rst = 0;
        cyc(1, T_IDLE, 0);
        do_j();
        do_j();
        do_j();
`ifdef MC_CTRL_PERF_EN
        check("instr_cnt_3j", instr_cnt, 32'd3);
        check("cyc_cnt_3j", cyc_cnt, 32'd9);
`endif

        repeat (5) @(posedge clk);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
